oqpsk_chip_combiner: RTL and testbench

Receive-side counterpart of the O-QPSK offset splitter. It takes two chip streams: the I (leading-edge) stream and the Q (trailing-edge) stream, which is offset by half a chip period. It samples them alternately at the half-chip rate and rebuilds the serial chip stream. It also packs the chips into fixed-length words (one 32-chip ZigBee symbol by default) for the despreader downstream.

---
 rtl/oqpsk_chip_combiner.sv | 103 ++++++++++
 tb/tb_oqpsk_chip_combiner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/oqpsk_chip_combiner.sv
// O-QPSK receive-side chip combiner: samples the I and Q chip streams alternately at
// the end of each half-chip window, rebuilds the serial chip stream and packs it into words.
module oqpsk_chip_combiner #(
  parameter int HALF_PERIOD = 2,
  parameter int WORD_LEN    = 32,
  parameter int CNT_W       = 8
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_EN,
  input  logic                i_DATA_I,
  input  logic                i_DATA_Q,
  output logic                o_CHIP,
  output logic                o_CHIP_VALID,
  output logic [WORD_LEN-1:0] o_WORD,
  output logic                o_WORD_VALID
);

  typedef enum logic {SEL_I = 1'b0, SEL_Q = 1'b1} sel_e;

  localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_LEN - 1);

  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]    chip_cnt_q, chip_cnt_d;
  sel_e                sel_q, sel_d;
  // The last chip of a word goes straight into o_WORD, so only WORD_LEN-1 chips are buffered.
  logic [WORD_LEN-2:0] shift_q, shift_d;
  logic                chip_q, chip_d;
  logic                chip_valid_q, chip_valid_d;
  logic [WORD_LEN-1:0] word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                sample;

  assign sample = (sel_q == SEL_I) ? i_DATA_I : i_DATA_Q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    div_cnt_d    = div_cnt_q;
    chip_cnt_d   = chip_cnt_q;
    sel_d        = sel_q;
    shift_d      = shift_q;
    chip_d       = chip_q;
    word_d       = word_q;
    chip_valid_d = 1'b0;
    word_valid_d = 1'b0;

    if (!i_EN) begin
      // Idle resynchronises the phase and discards any partial word; o_CHIP/o_WORD hold.
      div_cnt_d  = '0;
      chip_cnt_d = '0;
      sel_d      = SEL_I;
      shift_d    = '0;
    end else if (div_cnt_q != HP_LAST) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end else begin
      div_cnt_d    = '0;
      chip_d       = sample;
      chip_valid_d = 1'b1;
      sel_d        = (sel_q == SEL_I) ? SEL_Q : SEL_I;
      if (chip_cnt_q == WORD_LAST) begin
        word_d       = {sample, shift_q};
        word_valid_d = 1'b1;
        chip_cnt_d   = '0;
        shift_d      = '0;
      end else begin
        chip_cnt_d = chip_cnt_q + CNT_W'(1);
        for (int i = 0; i < WORD_LEN - 1; i++) begin
          if (chip_cnt_q == CNT_W'(i)) shift_d[i] = sample;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      div_cnt_q    <= '0;
      chip_cnt_q   <= '0;
      sel_q        <= SEL_I;
      shift_q      <= '0;
      chip_q       <= 1'b0;
      chip_valid_q <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      chip_cnt_q   <= chip_cnt_d;
      sel_q        <= sel_d;
      shift_q      <= shift_d;
      chip_q       <= chip_d;
      chip_valid_q <= chip_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign o_CHIP       = chip_q;
  assign o_CHIP_VALID = chip_valid_q;
  assign o_WORD       = word_q;
  assign o_WORD_VALID = word_valid_q;

endmodule

// File: tb/tb_oqpsk_chip_combiner.sv
// Directed bench for oqpsk_chip_combiner: a HALF_PERIOD=2 instance for the main scenarios
// and a HALF_PERIOD=1 instance for the continuous-strobe case.
module tb_oqpsk_chip_combiner;

  localparam int HP = 2;
  localparam int WL = 32;

  logic          clk;
  logic          rst_n;
  logic          en, data_i, data_q;
  logic          chip, chip_valid, word_valid;
  logic [WL-1:0] word;
  logic          en1, data_i1, data_q1;
  logic          chip1, chip_valid1, word_valid1;
  logic [WL-1:0] word1;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          exp_chip_hold = 1'b0;
  logic [WL-1:0] exp_word_hold = '0;
  int            word_pulses;

  oqpsk_chip_combiner #(.HALF_PERIOD(HP), .WORD_LEN(WL), .CNT_W(8)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_EN(en), .i_DATA_I(data_i), .i_DATA_Q(data_q),
    .o_CHIP(chip), .o_CHIP_VALID(chip_valid), .o_WORD(word), .o_WORD_VALID(word_valid)
  );

  oqpsk_chip_combiner #(.HALF_PERIOD(1), .WORD_LEN(WL), .CNT_W(8)) dut_hp1 (
    .i_CLK(clk), .i_RST(rst_n), .i_EN(en1), .i_DATA_I(data_i1), .i_DATA_Q(data_q1),
    .o_CHIP(chip1), .o_CHIP_VALID(chip_valid1), .o_WORD(word1), .o_WORD_VALID(word_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives the serial chips seq[0..n-1] as offset I/Q streams starting from an idle DUT,
  // checks every output on every edge, then idles for one edge and checks the hold.
  task automatic drive_seq(input logic [127:0] seq, input int n, input string tag);
    int  k;
    logic exp_cv, exp_wv;
    for (int e = 1; e <= n * HP; e++) begin
      en     = 1'b1;
      data_i = seq[2 * ((e - 1) / (2 * HP))];
      data_q = (e > HP) ? seq[2 * ((e - 1 - HP) / (2 * HP)) + 1] : 1'b0;
      tick();
      exp_cv = ((e % HP) == 0);
      check_bit({tag, "_chip_valid"}, chip_valid, exp_cv);
      exp_wv = 1'b0;
      if (exp_cv) begin
        k = e / HP - 1;
        exp_chip_hold = seq[k];
        check_bit({tag, "_chip"}, chip, exp_chip_hold);
        exp_wv = (((k + 1) % WL) == 0);
        if (exp_wv) begin
          exp_word_hold = seq[k - (WL - 1) +: WL];
          word_pulses++;
        end
      end
      check_bit({tag, "_word_valid"}, word_valid, exp_wv);
      check_word({tag, "_word"}, word, exp_word_hold);
    end
    en     = 1'b0;
    data_i = 1'b0;
    data_q = 1'b0;
    tick();
    check_bit({tag, "_idle_chip_valid"}, chip_valid, 1'b0);
    check_bit({tag, "_idle_word_valid"}, word_valid, 1'b0);
    check_bit({tag, "_idle_chip_hold"}, chip, exp_chip_hold);
    check_word({tag, "_idle_word_hold"}, word, exp_word_hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      en = 1'b1; en1 = 1'b1;
      data_i = c[0]; data_q = ~c[0]; data_i1 = 1'b1; data_q1 = c[1];
      tick();
      check_bit("rst_chip", chip, 1'b0);
      check_bit("rst_chip_valid", chip_valid, 1'b0);
      check_bit("rst_word_valid", word_valid, 1'b0);
      check_word("rst_word", word, '0);
      check_bit("rst_hp1_chip_valid", chip_valid1, 1'b0);
    end
    en = 1'b0; en1 = 1'b0; data_i = 1'b0; data_q = 1'b0; data_i1 = 1'b0; data_q1 = 1'b0;
    rst_n = 1'b1;
    tick();
    check_bit("post_rst_chip_valid", chip_valid, 1'b0);
  endtask

  task automatic test_basic_merge();
    // I chips 1,0,1,1 and Q chips 0,0,1,0 interleave to 1,0,0,0,1,1,1,0 (chip 0 = bit 0).
    drive_seq(128'h71, 8, "merge");
  endtask

  task automatic test_word();
    drive_seq({96'h0, 32'h744AC39B}, 32, "word0");
  endtask

  task automatic test_enable_drop();
    // 11 chips leave sel on Q and chip_cnt at 11; re-enabling must restart both.
    drive_seq({96'h0, 32'hFFFF_FFFF}, 11, "drop_partial");
    drive_seq({96'h0, 32'h0F0F_3C5A}, 32, "drop_next");
  endtask

  task automatic test_en_strobe_collision();
    en = 1'b1; data_i = ~exp_chip_hold; data_q = ~exp_chip_hold;
    tick();
    check_bit("coll_first_edge_valid", chip_valid, 1'b0);
    en = 1'b0;
    tick();
    check_bit("coll_chip_valid", chip_valid, 1'b0);
    check_bit("coll_chip_hold", chip, exp_chip_hold);
    check_bit("coll_word_valid", word_valid, 1'b0);
    drive_seq(128'hA6, 8, "coll_after");
  endtask

  task automatic test_back_to_back();
    word_pulses = 0;
    drive_seq({32'h0, 32'h4AC39B74, 32'h44AC39B7, 32'h744AC39B}, 96, "b2b");
    n_checks++;
    if (word_pulses != 3) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d expected 3", word_pulses);
    end
  endtask

  task automatic test_hp1();
    en1 = 1'b1; data_i1 = 1'b1; data_q1 = 1'b0;
    for (int e = 1; e <= WL; e++) begin
      tick();
      check_bit("hp1_chip_valid", chip_valid1, 1'b1);
      check_bit("hp1_chip", chip1, (e % 2) == 1);
      check_bit("hp1_word_valid", word_valid1, e == WL);
    end
    check_word("hp1_word", word1, 32'h5555_5555);
    en1 = 1'b0;
    tick();
    check_bit("hp1_idle_valid", chip_valid1, 1'b0);
  endtask

  task automatic test_async_reset();
    en = 1'b1; data_i = 1'b1; data_q = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("arst_chip", chip, 1'b0);
    check_bit("arst_chip_valid", chip_valid, 1'b0);
    check_word("arst_word", word, '0);
    check_word("arst_hp1_word", word1, '0);
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    exp_chip_hold = 1'b0;
    exp_word_hold = '0;
    tick();
    drive_seq({96'h0, 32'h1234_5678}, 32, "arst_after");
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; data_i = 1'b0; data_q = 1'b0;
    en1 = 1'b0; data_i1 = 1'b0; data_q1 = 1'b0;
    word_pulses = 0;
    test_reset();
    test_basic_merge();
    test_word();
    test_enable_drop();
    test_en_strobe_collision();
    test_back_to_back();
    test_hp1();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
